// File: rtl/q_update_unit.sv
// q_update_unit: Q-table write-back engine, Q <- sat(Q + alpha*(r + gamma*maxQ - Q)) in Q8.8
//   clk, rst                   clock, asynchronous active-high reset
//   upd_valid/upd_ready        request handshake (ready while idle)
//   upd_state/upd_action       Q-table coordinates {s,a}
//   upd_reward/upd_max_q       signed Q8.8 reward, unsigned Q8.8 next-state max Q
//   mem_rd_en/mem_rd_data      Q-table read strobe, data one cycle later
//   mem_wr_en/mem_wr_data      Q-table write strobe and updated value
//   mem_addr                   {state,action}, held outside RD/WR
//   upd_done/upd_err           completion pulse (with write), illegal-action pulse
module q_update_unit #(
  parameter int DATA_W      = 16,
  parameter int STATE_W     = 6,
  parameter int ACT_W       = 4,
  parameter int NUM_ACT     = 15,
  parameter int GAMMA       = 230,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [STATE_W-1:0]       upd_state,
  input  logic [ACT_W-1:0]         upd_action,
  input  logic [DATA_W-1:0]        upd_reward,
  input  logic [DATA_W-1:0]        upd_max_q,
  output logic                     mem_rd_en,
  output logic                     mem_wr_en,
  output logic [STATE_W+ACT_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]        mem_rd_data,
  output logic [DATA_W-1:0]        mem_wr_data,
  output logic                     upd_done,
  output logic                     upd_err
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, CALC, WR} state_t;
  localparam logic [7:0]     G  = 8'(GAMMA);
  localparam logic [ACT_W:0] NA = (ACT_W+1)'(NUM_ACT);
  state_t                     state_q, state_d;
  logic [DATA_W-1:0]          r_q, mq_q, qold_q, wr_data_q, q_new;
  logic [STATE_W+ACT_W-1:0]   addr_q;
  logic                       rd_en_q, wr_en_q, done_q, err_q;
  logic                       accept, legal;
  logic [DATA_W+7:0]          prod;
  logic [DATA_W-1:0]          gm;
  logic signed [DATA_W+1:0]   targ, diff, delta;
  logic signed [DATA_W+2:0]   sum;
  assign upd_ready   = (state_q == IDLE) && !rst;
  assign accept      = upd_valid && upd_ready;
  assign legal       = {1'b0, upd_action} < NA;
  assign mem_rd_en   = rd_en_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wr_data_q;
  assign upd_done    = done_q;
  assign upd_err     = err_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = (accept && legal) ? RD : IDLE;
      RD:      state_d = WAIT;
      WAIT:    state_d = CALC;
      CALC:    state_d = WR;
      default: state_d = IDLE;
    endcase
  end
  // Two guard bits keep reward+gm and the subtraction exact; a third catches
  // the sign of q_old+delta so the clamp sees the true result.
  always_comb begin
    prod  = (DATA_W+8)'(G) * (DATA_W+8)'(mq_q);
    gm    = prod[DATA_W+7:8];
    targ  = $signed({{2{r_q[DATA_W-1]}}, r_q}) + $signed({2'b00, gm});
    diff  = targ - $signed({2'b00, qold_q});
    delta = diff >>> ALPHA_SHIFT;
    sum   = $signed({3'b000, qold_q}) + $signed({delta[DATA_W+1], delta});
    q_new = sum[DATA_W+2] ? '0 : (|sum[DATA_W+1:DATA_W]) ? '1 : sum[DATA_W-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      r_q       <= '0;
      mq_q      <= '0;
      qold_q    <= '0;
      wr_data_q <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        r_q  <= upd_reward;
        mq_q <= upd_max_q;
      end
      if (accept && legal) addr_q <= {upd_state, upd_action};
      if (state_q == WAIT) qold_q <= mem_rd_data;
      if (state_q == CALC) wr_data_q <= q_new;
      rd_en_q <= accept && legal;
      wr_en_q <= state_q == CALC;
      done_q  <= state_q == CALC;
      err_q   <= accept && !legal;
    end
  end
endmodule

// File: tb/tb_q_update_unit.sv
// tb_q_update_unit: directed self-checking bench for q_update_unit with a 1-cycle-latency RAM model
module tb_q_update_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        upd_valid = 1'b0, upd_ready;
  logic [5:0]  upd_state = '0;
  logic [3:0]  upd_action = '0;
  logic [15:0] upd_reward = '0, upd_max_q = '0;
  logic        mem_rd_en, mem_wr_en, upd_done, upd_err;
  logic [9:0]  mem_addr;
  logic [15:0] mem_rd_data = '0, mem_wr_data;
  logic [15:0] ram [0:1023];
  int          n_tests = 0, n_fail = 0, n_wr = 0, n_rd = 0;
  q_update_unit dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_state(upd_state), .upd_action(upd_action), .upd_reward(upd_reward),
    .upd_max_q(upd_max_q), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_data(mem_wr_data),
    .upd_done(upd_done), .upd_err(upd_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= ram[mem_addr];
      n_rd <= n_rd + 1;
    end
    if (mem_wr_en) begin
      ram[mem_addr] <= mem_wr_data;
      n_wr <= n_wr + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic do_upd(input string tag, input logic [5:0] s, input logic [3:0] a,
                        input logic [15:0] r, input logic [15:0] mq, input logic [15:0] exp);
    upd_valid = 1'b1; upd_state = s; upd_action = a; upd_reward = r; upd_max_q = mq;
    chk({tag, " ready"}, 32'(upd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    chk({tag, " rd_en"}, 32'(mem_rd_en), 32'd1);
    chk({tag, " rd_addr"}, 32'(mem_addr), 32'({s, a}));
    chk({tag, " busy"}, 32'(upd_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk({tag, " no_early_wr"}, 32'(mem_wr_en), 32'd0);
    @(negedge clk);
    chk({tag, " wr_en"}, 32'(mem_wr_en), 32'd1);
    chk({tag, " done"}, 32'(upd_done), 32'd1);
    chk({tag, " wr_addr"}, 32'(mem_addr), 32'({s, a}));
    chk({tag, " wr_data"}, 32'(mem_wr_data), 32'(exp));
    @(negedge clk);
    chk({tag, " done_clr"}, 32'(upd_done), 32'd0);
    chk({tag, " ram"}, 32'(ram[{s, a}]), 32'(exp));
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    ram[{6'd3, 4'd2}]  = 16'h0100;
    ram[{6'd5, 4'd7}]  = 16'h0800;
    ram[{6'd9, 4'd14}] = 16'h0010;
    ram[{6'd63, 4'd0}] = 16'hFF00;
    ram[{6'd20, 4'd1}] = 16'h0100;
    ram[{6'd21, 4'd3}] = 16'h0100;
    repeat (2) @(negedge clk);
    chk("rst ready", 32'(upd_ready), 32'd0);
    chk("rst outs", {27'd0, mem_rd_en, mem_wr_en, upd_done, upd_err, |mem_addr}, 32'd0);
    chk("rst wr_data", 32'(mem_wr_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle ready", 32'(upd_ready), 32'd1);
    do_upd("T1", 6'd3, 4'd2, 16'h0100, 16'h0200, 16'h0173);
    do_upd("T2", 6'd5, 4'd7, 16'hFC00, 16'h0000, 16'h0500);
    do_upd("T3", 6'd9, 4'd14, 16'h8000, 16'h0000, 16'h0000);
    do_upd("T4", 6'd63, 4'd0, 16'h7FFF, 16'hFFFF, 16'hFFFF);
    upd_valid = 1'b1; upd_state = 6'd1; upd_action = 4'd15;
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    chk("T5 err", 32'(upd_err), 32'd1);
    chk("T5 rd_en", 32'(mem_rd_en), 32'd0);
    chk("T5 ready", 32'(upd_ready), 32'd1);
    @(negedge clk);
    chk("T5 err_clr", 32'(upd_err), 32'd0);
    repeat (4) @(negedge clk);
    chk("T5 no_rd", 32'(n_rd), 32'd4);
    chk("T5 no_wr", 32'(n_wr), 32'd4);
    upd_valid = 1'b1; upd_state = 6'd20; upd_action = 4'd1;
    upd_reward = 16'h0100; upd_max_q = 16'h0200;
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("T6 rst ready", 32'(upd_ready), 32'd0);
    chk("T6 rst outs", {27'd0, mem_rd_en, mem_wr_en, upd_done, upd_err, |mem_addr}, 32'd0);
    chk("T6 rst wr_data", 32'(mem_wr_data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("T6 no_wr", 32'(n_wr), 32'd4);
    chk("T6 ram_kept", 32'(ram[{6'd20, 4'd1}]), 32'h0100);
    chk("T6 ready", 32'(upd_ready), 32'd1);
    do_upd("T6b", 6'd21, 4'd3, 16'h0100, 16'h0200, 16'h0173);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
